store_serializer: RTL and testbench

STORE_SERIALIZER -- requirements
Module: store_serializer

---
 rtl/minirisc_pkg.sv | 39 +++
 rtl/narrow_fit_chk.sv | 20 ++
 rtl/store_serializer.sv | 138 +++++++++++++
 tb/tb_store_serializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/minirisc_pkg.sv
// Shared encodings for the mini-RISC store path: access sizes, FSM state type,
// and helpers that decode a store request's size/alignment.
package minirisc_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // A request is legal when its size is defined and the address is naturally aligned.
  function automatic logic req_legal(input logic [1:0] sz, input logic [1:0] addr_lo);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Index of the final byte to write (N-1).
  function automatic logic [1:0] last_index(input logic [1:0] sz);
    logic [1:0] idx;
    case (sz)
      SZ_HALF: idx = 2'd1;
      SZ_WORD: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/narrow_fit_chk.sv
// Reports whether a 32-bit register value survives narrowing to the store size
// as a sign-extended quantity (upper bits all equal to the kept sign bit).
module narrow_fit_chk
  import minirisc_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic [1:0]  i_size,
  output logic        o_fits
);

  always_comb begin
    o_fits = 1'b1;
    case (i_size)
      SZ_BYTE: o_fits = (&i_value[31:7])  | ~(|i_value[31:7]);
      SZ_HALF: o_fits = (&i_value[31:15]) | ~(|i_value[31:15]);
      default: o_fits = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_serializer.sv
// Serializes a byte/half/word store into little-endian byte writes.
// Optional narrowing-overflow flag is built only when STORE_OVF_CHECK_EN is defined.
module store_serializer
  import minirisc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data,
  input  logic [1:0]            size,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ready,
  output logic [1:0]            o_dbg_state
);

  state_t                r_state;
  logic [31:0]           r_data;
  logic [1:0]            r_idx;
  logic [1:0]            r_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_wdata;

  logic       w_legal;
  logic       w_handshake;
  logic       w_last_hs;
  logic [1:0] w_next_idx;
  logic [7:0] w_next_byte;

  // Memory handshake: a byte transfers on a rising edge where mem_we and mem_ready
  // are both high; mem_we/mem_addr/mem_wdata hold unchanged until that happens.
  assign w_legal     = req_legal(size, addr[1:0]);
  assign w_handshake = r_mem_we & mem_ready;
  assign w_last_hs   = (r_state == ST_WRITE) & w_handshake & (r_idx == r_last);
  assign w_next_idx  = r_idx + 2'd1;
  assign w_next_byte = r_data[{w_next_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_idx       <= 2'd0;
      r_last      <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_state     <= ST_WRITE;
              r_data      <= data;
              r_idx       <= 2'd0;
              r_last      <= last_index(size);
              r_busy      <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= addr;
              r_mem_wdata <= data[7:0];
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (w_handshake) begin
            if (r_idx == r_last) begin
              r_state  <= ST_FINISH;
              r_mem_we <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_idx       <= w_next_idx;
              r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(1);
              r_mem_wdata <= w_next_byte;
            end
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef STORE_OVF_CHECK_EN
  logic [1:0] r_size;
  logic       r_ovf;
  logic       w_fits;

  narrow_fit_chk u_fit_chk (
    .i_value (r_data),
    .i_size  (r_size),
    .o_fits  (w_fits)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_size <= SZ_BYTE;
      r_ovf  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start && w_legal) r_size <= size;
      r_ovf <= w_last_hs & ~w_fits;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_last_hs;
  assign w_unused_last_hs = w_last_hs;
  assign ovf = 1'b0;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_store_serializer.sv
// Bench for store_serializer: directed cases plus randomized stores/stalls checked
// against a queue of expected byte writes. Define STORE_OVF_CHECK_EN to expect ovf.
module tb_store_serializer;

  localparam int AW = 32;
  localparam int W  = AW + 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   data = '0;
  logic [1:0]    size = '0;
  logic          mem_ready = 1'b1;
  logic          busy, done, err, ovf, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [1:0]    dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  store_serializer #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .addr        (addr),
    .data        (data),
    .size        (size),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ovf         (ovf),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit model_legal(input logic [1:0] sz, input logic [AW-1:0] a);
    int n;
    if (sz == 2'b11) return 1'b0;
    n = 1 << sz;
    return (a % n) == 0;
  endfunction

  function automatic bit model_ovf(input logic [1:0] sz, input logic [31:0] d);
    int signed v;
    v = $signed(d);
    if (sz == 2'b00) return (v < -128) || (v > 127);
    if (sz == 2'b01) return (v < -32768) || (v > 32767);
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One store: pushes expected writes, handshakes with optional stalls, and
  // throws ignored start pulses at the DUT while it is busy and in its done cycle.
  task automatic run_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int stall_pct, input int stall_first);
    int n, stalls, cyc, pending;
    bit seen_done, exp_ovf;
    logic [W-1:0] head;
    n = 1 << sz;
    for (int k = 0; k < n; k++) exp_q.push_back({a + AW'(k), d[8*k +: 8]});
`ifdef STORE_OVF_CHECK_EN
    exp_ovf = model_ovf(sz, d);
`else
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    start = 1'b1; addr = a; data = d; size = sz;
    stalls = 0; cyc = 0; seen_done = 1'b0; pending = stall_first;
    while (!seen_done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (mem_we) begin
        check("busy_during_write", busy, 1);
        if (exp_q.size() == 0) check("extra_write", 1, 0);
        else begin
          head = exp_q[0];
          check("wr_addr", mem_addr, head[W-1:8]);
          check("wr_data", mem_wdata, head[7:0]);
        end
        if (pending > 0) begin
          mem_ready = 1'b0; pending--; stalls++;
        end else if ($urandom_range(0, 99) < stall_pct) begin
          mem_ready = 1'b0; stalls++;
        end else begin
          mem_ready = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        start = ($urandom_range(0, 1) == 1);
        addr = $urandom; data = $urandom; size = 2'($urandom_range(0, 3));
      end else if (done) begin
        seen_done = 1'b1;
        check("done_cycle", cyc, n + 1 + stalls);
        check("ovf_with_done", ovf, exp_ovf);
        check("busy_at_done", busy, 0);
        check("writes_drained", exp_q.size(), 0);
        start = 1'b1; addr = $urandom; data = $urandom; size = 2'b00;
      end else begin
        check("write_gap", mem_we, 1);
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    exp_q.delete();
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b1;
    check("done_one_cycle", done, 0);
    check("idle_we", mem_we, 0);
    check("idle_busy", busy, 0);
    check("idle_ovf", ovf, 0);
  endtask

  task automatic run_reject(input logic [AW-1:0] a, input logic [1:0] sz);
    @(negedge clk);
    start = 1'b1; addr = a; data = $urandom; size = sz;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_no_we", mem_we, 0);
    check("err_no_busy", busy, 0);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("err_no_we_after", mem_we, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] ra;
    logic [31:0]   rd;
    logic [1:0]    rs;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    run_store(32'h103, 32'h0000_007F, 2'b00, 0, 0);
    run_store(32'h200, 32'hA1B2_C3D4, 2'b10, 0, 0);
    run_store(32'h010, 32'h0000_1234, 2'b01, 0, 3);
    run_reject(32'h6, 2'b10);
    run_reject(32'h8, 2'b11);
    run_reject(32'h5, 2'b01);
    run_store(32'h020, 32'h0000_0080, 2'b00, 0, 0);
    run_store(32'h021, 32'hFFFF_FF80, 2'b00, 0, 0);
    run_store(32'h040, 32'h0001_8000, 2'b01, 0, 0);

    // Reset while the second byte of a word store is on the bus.
    @(negedge clk);
    start = 1'b1; addr = 32'h300; data = 32'hDEAD_BEEF; size = 2'b10; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_b0_addr", mem_addr, 32'h300);
    @(negedge clk);
    check("abort_b1_addr", mem_addr, 32'h301);
    check("abort_b1_data", mem_wdata, 8'hBE);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_we", mem_we, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_no_we", mem_we, 0);
    end
    run_store(32'h304, 32'h0BAD_F00D, 2'b10, 0, 0);

    // Randomized requests with random back-pressure.
    for (int i = 0; i < 30; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      rd = $urandom;
      if ($urandom_range(0, 1) == 1) rd = {{24{rd[7]}}, rd[7:0]};
      if (model_legal(rs, ra)) run_store(ra, rd, rs, 30, 0);
      else run_reject(ra, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
